// File: rtl/button_conditioner_pkg.sv
// Shared debounce FSM encoding and default timing constants for button_conditioner.
package button_conditioner_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } deb_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_REPEAT_DELAY    = 64;
   localparam int DEF_REPEAT_PERIOD   = 32;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button: 2-FF sync + debounce FSM; raw_pulse is combinational (registered by the top), held tracks the debounced level.
// No backpressure; BUTTON_REPEAT_EN adds an auto-repeat counter that re-fires raw_pulse while PRESSED.
module debounce_channel
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic raw_pulse,
   output logic held
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_meta;
   logic          sync;
   deb_state_t    state;
   logic [CW-1:0] cnt;
   logic          press_pulse;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
      end else begin
         sync_meta <= btn_raw;
         sync      <= sync_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RELEASED;
         cnt   <= '0;
      end else begin
         case (state)
            RELEASED: begin
               if (sync) begin
                  state <= PRESS_WAIT;
                  cnt   <= CW'(1);
               end
            end
            PRESS_WAIT: begin
               if (!sync) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (!sync) begin
                  state <= RELEASE_WAIT;
                  cnt   <= CW'(1);
               end
            end
            RELEASE_WAIT: begin
               if (sync) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= RELEASED;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Asserted in the cycle the FSM commits to PRESSED, so the top's register lands on the same edge as held.
   assign press_pulse = (state == PRESS_WAIT) && sync && (cnt == CNT_LAST);
   assign held        = (state == PRESSED) || (state == RELEASE_WAIT);

`ifdef BUTTON_REPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = $clog2(RPT_MAX + 1);

   logic [RW-1:0] rpt_cnt;
   logic          rpt_first;
   logic          rpt_fire;

   // rpt_cnt counts cycles since the last pulse; it freezes in RELEASE_WAIT so a short release resumes the cadence.
   assign rpt_fire = (state == PRESSED) &&
                     (rpt_cnt == (rpt_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD)));

   always_ff @(posedge clk) begin
      if (rst || state == RELEASED) begin
         rpt_cnt   <= '0;
         rpt_first <= 1'b1;
      end else if (press_pulse) begin
         rpt_cnt   <= RW'(1);
         rpt_first <= 1'b1;
      end else if (rpt_fire) begin
         rpt_cnt   <= RW'(1);
         rpt_first <= 1'b0;
      end else if (state == PRESSED) begin
         rpt_cnt <= rpt_cnt + 1'b1;
      end
   end

   assign raw_pulse = press_pulse | rpt_fire;
`else
   localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;

   assign raw_pulse = press_pulse;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Up/down button conditioner: two debounce channels, up-over-down arbitration, registered pulses; latency DEBOUNCE_CYCLES+1 edges.
// No backpressure (pulses are fire-and-forget); BUTTON_REPEAT_EN enables auto-repeat while held.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic up_raw,
   input  logic down_raw,
   output logic up_pulse,
   output logic down_pulse,
   output logic up_held,
   output logic down_held
);

   logic up_raw_pulse;
   logic down_raw_pulse;

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
   ) u_up (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (up_raw),
      .raw_pulse (up_raw_pulse),
      .held      (up_held)
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
   ) u_down (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (down_raw),
      .raw_pulse (down_raw_pulse),
      .held      (down_held)
   );

   // A coincident down pulse is dropped outright rather than queued behind up.
   always_ff @(posedge clk) begin
      if (rst) begin
         up_pulse   <= 1'b0;
         down_pulse <= 1'b0;
      end else begin
         up_pulse   <= up_raw_pulse;
         down_pulse <= down_raw_pulse & ~up_raw_pulse;
      end
   end

endmodule
